ram_burst_reader: RTL and testbench

// - Read-side initiator for the single-port synchronous RAM. Walks LEN consecutive

---
 rtl/ram_burst_reader_if.sv | 46 ++++
 rtl/ram_burst_reader.sv | 154 +++++++++++++++
 tb/tb_ram_burst_reader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_reader_if.sv
// Bus bundle between ram_burst_reader, the single-port RAM and the stream consumer.
// Ports (signals):
//   ram_we, ram_addr, ram_data_in  : reader -> RAM (write side is tied off)
//   ram_data_out                   : RAM -> reader, valid 1 clk after addr
//   out_valid, out_data, out_last  : reader -> consumer stream
//   out_ready                      : consumer -> reader backpressure
// Modports: master = reader side, slave = RAM/consumer side.

interface ram_burst_reader_if #(
    parameter int data_width = 8,
    parameter int addr_width = 4
);

    logic                  ram_we;
    logic [addr_width-1:0] ram_addr;
    logic [data_width-1:0] ram_data_in;
    logic [data_width-1:0] ram_data_out;

    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] out_data;
    logic                  out_last;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_data_in,
        input  ram_data_out,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_data_in,
        output ram_data_out,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/ram_burst_reader.sv
// Read-side burst initiator for a single-port synchronous RAM: walks len
// consecutive addresses from base_addr (wrapping) and streams the words out.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, base_addr  : burst request (sampled only when idle) and first address
//   len               : word count, 0..2**addr_width
//   busy, done        : burst in progress / 1-clk completion pulse
//   bus (master)      : RAM addr/we/data ports plus valid/ready/last stream

module ram_burst_reader #(
    parameter int data_width = 8,
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width:0]   len,
    output logic                  busy,
    output logic                  done,
    ram_burst_reader_if.master    bus
);

    localparam int CW = addr_width + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_e;

    state_e                           state_q, state_d;
    logic [addr_width-1:0]            addr_q, addr_d;
    logic [CW-1:0]                    left_q, left_d;
    logic                             infl_q, infl_d;
    logic                             infl_last_q, infl_last_d;
    logic                             done_q, done_d;
    logic [1:0][data_width-1:0]       buf_data_q, buf_data_d;
    logic [1:0]                       buf_last_q, buf_last_d;
    logic                             wr_ptr_q, wr_ptr_d;
    logic                             rd_ptr_q, rd_ptr_d;
    logic [1:0]                       cnt_q, cnt_d;

    logic                             out_valid;
    logic                             pop;
    logic                             issue;
    logic [2:0]                       occ;

    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid && bus.out_ready;

    // Occupancy seen by a new issue: words held plus the word returning
    // from the RAM, minus the word leaving this clk. Counting the pop
    // keeps one issue per clk under full ready without overfilling.
    assign occ   = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
    assign issue = (state_q == S_READ) && (left_q != '0) && (occ < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
            buf_data_q  <= '0;
            buf_last_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        infl_d      = issue;
        infl_last_d = issue && (left_q == CW'(1));
        done_d      = 1'b0;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + 2'(infl_q) - 2'(pop);

        // The RAM word for the address issued last clk is on ram_data_out now.
        if (infl_q) begin
            buf_data_d[wr_ptr_q] = bus.ram_data_out;
            buf_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (issue) begin
            addr_d = addr_q + 1'b1;
            left_d = left_q - 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d  = base_addr;
                        left_d  = len;
                        state_d = S_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (issue && (left_q == CW'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && buf_last_q[rd_ptr_q]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

    assign bus.ram_we      = 1'b0;
    assign bus.ram_data_in = '0;
    assign bus.ram_addr    = addr_q;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = buf_data_q[rd_ptr_q];
    assign bus.out_last    = out_valid && buf_last_q[rd_ptr_q];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Testbench for ram_burst_reader: RAM model with preload mux, directed bursts,
// expected-word queue drained by an independent stream monitor.

module tb_ram_burst_reader;

    localparam int DW = 8;
    localparam int AW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;

    ram_burst_reader_if #(.data_width(DW), .addr_width(AW)) bus ();

    ram_burst_reader #(.data_width(DW), .addr_width(AW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .len(len),
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // RAM model; the bench owns the port while pre=1 to load contents.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_q = '0;
    logic          pre = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre) mem[pre_addr] <= pre_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data_in;
        rd_q <= mem[pre ? pre_addr : bus.ram_addr];
    end

    assign bus.ram_data_out = rd_q;

    function automatic logic [DW-1:0] init_val(int i);
        case (i)
            0:       return 8'h3C;
            1:       return 8'h7E;
            3:       return 8'hA1;
            4:       return 8'hD5;
            15:      return 8'h5A;
            default: return 8'(8'h10 + i);
        endcase
    endfunction

    int    total = 0;
    int    bad = 0;
    int    hs_cnt = 0;
    word_t sbq[$];
    word_t e_w;
    word_t held;
    logic  hold = 1'b0;
    logic  side_err = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Stream monitor: stability under backpressure and in-order word check.
    always @(negedge clk) begin
        if (bus.ram_we !== 1'b0 || bus.ram_data_in !== 8'h00) side_err = 1'b1;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held.d ||
                    bus.out_last !== held.l) begin
                    bad++;
                    $display("FAIL stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             bus.out_valid, bus.out_data, bus.out_last,
                             held.d, held.l);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL word: got d=%h l=%b want none",
                             bus.out_data, bus.out_last);
                end else begin
                    e_w = sbq.pop_front();
                    if (bus.out_data !== e_w.d || bus.out_last !== e_w.l) begin
                        bad++;
                        $display("FAIL word: got d=%h l=%b want d=%h l=%b",
                                 bus.out_data, bus.out_last, e_w.d, e_w.l);
                    end
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            held = '{d: bus.out_data, l: bus.out_last};
        end
    end

    task automatic go(int b, int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = AW'(b);
        len = (AW+1)'(n);
        for (int i = 0; i < n; i++)
            sbq.push_back('{d: init_val((b + i) % 16), l: (i == n - 1)});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(string nm, int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(done), 32'd1);
        chk({nm, "_q"}, 32'(sbq.size()), 32'd0);
    endtask

    task automatic wait_valid(string nm, int budget);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        int hs0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_we", 32'(bus.ram_we), 32'd0);

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            pre = 1'b1;
            pre_addr = AW'(i);
            pre_data = init_val(i);
        end
        @(posedge clk);
        #1;
        pre = 1'b0;
        rst = 1'b0;

        // base 0 len 2, exact timing
        go(0, 2);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_addr0", 32'(bus.ram_addr), 32'd0);
        chk("t1_v_early", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("t1_v_early2", 32'(bus.out_valid), 32'd0);
        chk("t1_addr1", 32'(bus.ram_addr), 32'd1);
        @(negedge clk);
        chk("t1_v_first", 32'(bus.out_valid), 32'd1);
        chk("t1_d_first", 32'(bus.out_data), 32'h3C);
        @(negedge clk);
        chk("t1_last", 32'(bus.out_last), 32'd1);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_q", 32'(sbq.size()), 32'd0);

        // base 3 len 2 with backpressure
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        go(3, 2);
        wait_valid("t2_valid", 20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_d", 32'(bus.out_data), 32'hA1);
        end
        chk("t2_addr_stop", 32'(bus.ram_addr), 32'd5);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_done("t2_done", 20);

        // base 15 len 3, address wrap
        go(15, 3);
        @(negedge clk);
        chk("t3_addr15", 32'(bus.ram_addr), 32'd15);
        @(negedge clk);
        chk("t3_addr0", 32'(bus.ram_addr), 32'd0);
        @(negedge clk);
        chk("t3_addr1", 32'(bus.ram_addr), 32'd1);
        wait_done("t3_done", 20);

        // len 0
        @(negedge clk);
        go(0, 0);
        @(negedge clk);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t4_done_pulse", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_valid", 32'(bus.out_valid), 32'd0);

        // full-memory burst, back to back
        go(3, 16);
        wait_valid("t5_valid", 20);
        vc = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.out_valid === 1'b1) vc++;
            @(negedge clk);
        end
        chk("t5_b2b", 32'(vc), 32'd16);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_q", 32'(sbq.size()), 32'd0);

        // reset mid-burst, then a fresh burst
        hs0 = hs_cnt;
        go(0, 5);
        wait_valid("t6_valid", 20);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_hs", 32'(hs_cnt - hs0), 32'd2);
        chk("t6_valid0", 32'(bus.out_valid), 32'd0);
        chk("t6_busy0", 32'(busy), 32'd0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        go(4, 1);
        wait_done("t6_done", 20);

        chk("side_we_data", 32'(side_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
